dmem_responder: RTL

//   Memory-side responder for the core's MEM-stage load/store port. It replaces
//   the zero-wait combinational data memory with a handshaked slave that has

---
 rtl/dmem_responder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder for the MEM-stage load/store port.
// A request is held LATENCY cycles, committed to a byte-addressable array, then answered.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);
    // state | meaning
    // IDLE  | ready, waiting for a request
    // WAIT  | request latched, latency counter running
    // RESP  | response held until resp handshake
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   load_val;
    logic [31:0]   wr_data;
    logic [3:0]    be;
    logic          oor, illegal, misal, acc_err;
    logic          commit, mem_we;

    always_comb begin
        idx  = addr_q[AW+1:2];
        word = mem_q[idx];
        case (addr_q[1:0])
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        half_v = addr_q[1] ? word[31:16] : word[15:0];

        oor = |addr_q[31:AW+2];
        case (f3_q)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = we_q;
            default:                illegal = 1'b1;
        endcase
        case (f3_q[1:0])
            2'b01:   misal = addr_q[0];
            2'b10:   misal = |addr_q[1:0];
            default: misal = 1'b0;
        endcase
        acc_err = oor | illegal | misal;

        case (f3_q)
            3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_val = {{16{half_v[15]}}, half_v};
            3'b010:  load_val = word;
            3'b100:  load_val = {24'd0, byte_v};
            3'b101:  load_val = {16'd0, half_v};
            default: load_val = 32'd0;
        endcase

        // Sub-word stores replicate the data so the byte enables pick the lane
        case (f3_q[1:0])
            2'b00: begin
                wr_data = {4{wdata_q[7:0]}};
                be      = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                wr_data = {2{wdata_q[15:0]}};
                be      = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_data = wdata_q;
                be      = 4'b1111;
            end
        endcase

        commit = (state_q == ST_WAIT) && (cnt_q == 4'd0);
        mem_we = commit && we_q && !acc_err;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    f3_d    = req_funct3_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (commit) begin
                    rdata_d = (acc_err || we_q) ? 32'd0 : load_val;
                    err_d   = acc_err;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is deliberately not reset; a reset before commit leaves WAIT, so no write
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = (state_q == ST_RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule
